// File: rtl/coin_detector_if.sv
// Coin-chute front-end signal bundle.
// Sensor and downstream-busy in, coin strobes out.
interface coin_detector_if;
   logic coin_raw;
   logic hold;
   logic i;
   logic j;
   logic reject;
   logic jam;

   modport master (
      output coin_raw,
      output hold,
      input  i,
      input  j,
      input  reject,
      input  jam
   );

   modport slave (
      input  coin_raw,
      input  hold,
      output i,
      output j,
      output reject,
      output jam
   );
endinterface

// File: rtl/coin_detector.sv
// Coin detector: sync, debounce, width measure, classify,
// one-entry hold buffer feeding the vending FSM.
module coin_detector #(
   parameter int DEB_CYC   = 4,
   parameter int MIN_SMALL = 8,
   parameter int MAX_SMALL = 15,
   parameter int MIN_LARGE = 16,
   parameter int MAX_LARGE = 31,
   parameter int CNT_W     = 6
) (
   input logic clk,
   input logic rst,
   coin_detector_if.slave cif
);

   localparam int DW = $clog2(DEB_CYC + 1);

   localparam logic [CNT_W-1:0] CMAX   = '1;
   localparam logic [CNT_W-1:0] LO_S   = CNT_W'(MIN_SMALL);
   localparam logic [CNT_W-1:0] HI_S   = CNT_W'(MAX_SMALL);
   localparam logic [CNT_W-1:0] LO_L   = CNT_W'(MIN_LARGE);
   localparam logic [CNT_W-1:0] HI_L   = CNT_W'(MAX_LARGE);
   localparam logic [CNT_W-1:0] JAM_AT = CNT_W'(MAX_LARGE + 1);

   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
   localparam logic [DW-1:0] ARM_CNT  = DW'(DEB_CYC);

   if (!(MIN_SMALL <= MAX_SMALL && MAX_SMALL < MIN_LARGE &&
         MIN_LARGE <= MAX_LARGE &&
         MAX_LARGE < (1 << CNT_W) - 1)) begin : g_bad_cfg
      $error("coin_detector: inconsistent width limits");
   end

   typedef enum logic [1:0] {
      ARM,
      IDLE,
      MEASURE,
      CLASSIFY
   } state_t;

   state_t state;
   state_t state_n;

   logic s1;
   logic s2;
   logic filt;
   logic [DW-1:0] deb_cnt;
   logic [DW-1:0] arm_cnt;
   logic arm_done;

   logic [CNT_W-1:0] wcnt;
   logic [CNT_W-1:0] wcnt_n;
   logic [CNT_W-1:0] wcnt_inc;
   logic jam_q;
   logic jam_n;

   logic is_small;
   logic is_large;
   logic cls_ok;
   logic cls_bad;

   logic buf_full;
   logic buf_type;
   logic rej_pend;
   logic i_q;
   logic j_q;
   logic rej_q;

   // Level only moves after DEB_CYC disagreeing samples in a row
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         filt    <= 1'b0;
         deb_cnt <= '0;
      end else begin
         s1 <= cif.coin_raw;
         s2 <= s1;
         if (s2 == filt) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            filt    <= s2;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + DW'(1);
         end
      end
   end

   // Chute must read quiet for a full window before arming,
   // so a coin already in the chute at reset is skipped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arm_cnt <= '0;
      end else if (state != ARM || s2 || filt) begin
         arm_cnt <= '0;
      end else if (!arm_done) begin
         arm_cnt <= arm_cnt + DW'(1);
      end
   end

   assign arm_done = (arm_cnt == ARM_CNT);

   assign wcnt_inc = (wcnt == CMAX) ? wcnt : wcnt + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ARM;
         wcnt  <= '0;
         jam_q <= 1'b0;
      end else begin
         state <= state_n;
         wcnt  <= wcnt_n;
         jam_q <= jam_n;
      end
   end

   always_comb begin
      state_n  = state;
      wcnt_n   = wcnt;
      jam_n    = jam_q;
      is_small = 1'b0;
      is_large = 1'b0;
      cls_ok   = 1'b0;
      cls_bad  = 1'b0;
      unique case (state)
         ARM: begin
            if (arm_done) state_n = IDLE;
         end
         IDLE: begin
            if (filt) begin
               wcnt_n  = CNT_W'(1);
               state_n = MEASURE;
            end
         end
         MEASURE: begin
            if (filt) begin
               wcnt_n = wcnt_inc;
               if (wcnt_inc == JAM_AT) jam_n = 1'b1;
            end else begin
               jam_n   = 1'b0;
               state_n = CLASSIFY;
            end
         end
         CLASSIFY: begin
            is_small = (wcnt >= LO_S) && (wcnt <= HI_S);
            is_large = (wcnt >= LO_L) && (wcnt <= HI_L);
            cls_ok   = is_small || is_large;
            cls_bad  = !cls_ok;
            state_n  = IDLE;
         end
         default: state_n = ARM;
      endcase
   end

   // Buffer drain wins over a fresh coin; a width reject that
   // collides with a drain is pushed one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_q      <= 1'b0;
         j_q      <= 1'b0;
         rej_q    <= 1'b0;
         rej_pend <= 1'b0;
         buf_full <= 1'b0;
         buf_type <= 1'b0;
      end else begin
         i_q      <= 1'b0;
         j_q      <= 1'b0;
         rej_q    <= rej_pend;
         rej_pend <= 1'b0;
         if (buf_full && !cif.hold) begin
            i_q      <= 1'b1;
            j_q      <= buf_type;
            buf_full <= cls_ok;
            buf_type <= is_large;
            rej_pend <= cls_bad;
         end else if (cls_ok) begin
            if (!buf_full && !cif.hold) begin
               i_q <= 1'b1;
               j_q <= is_large;
            end else if (!buf_full) begin
               buf_full <= 1'b1;
               buf_type <= is_large;
            end else begin
               rej_q <= 1'b1;
            end
         end else if (cls_bad) begin
            rej_q <= 1'b1;
         end
      end
   end

   assign cif.i      = i_q;
   assign cif.j      = j_q;
   assign cif.reject = rej_q;
   assign cif.jam    = jam_q;

endmodule

// File: tb/tb_coin_detector.sv
// Scoreboard bench for coin_detector: stimulus queues expected
// strobes, a negedge monitor pops and compares them.
module tb_coin_detector;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   typedef struct {
      bit rej;
      bit j;
      int at;
   } exp_t;

   exp_t q[$];

   coin_detector_if cif ();

   coin_detector dut (
      .clk (clk),
      .rst (rst),
      .cif (cif)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cyc %0d)",
                  n, got, want, cyc);
      end
   endtask

   // Monitor: every strobe must match the head of the queue
   always @(negedge clk) begin
      if (!rst && (cif.i || cif.reject)) begin
         total++;
         if (cif.i && cif.reject) begin
            bad++;
            $display("FAIL excl: i=1 reject=1 at cyc %0d", cyc);
            if (q.size() > 0) void'(q.pop_front());
         end else if (q.size() == 0) begin
            bad++;
            $display("FAIL spurious: i=%b j=%b reject=%b cyc %0d, want none",
                     cif.i, cif.j, cif.reject, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (cif.reject !== e.rej ||
                (cif.i && cif.j !== e.j) ||
                (e.at >= 0 && cyc != e.at)) begin
               bad++;
               $display("FAIL strobe: got i=%b j=%b rej=%b cyc %0d, want rej=%b j=%b cyc %0d",
                        cif.i, cif.j, cif.reject, cyc, e.rej, e.j, e.at);
            end
         end
      end else if (q.size() > 0 && q[0].at >= 0 && cyc > q[0].at) begin
         total++;
         bad++;
         $display("FAIL missing: no strobe by cyc %0d, want rej=%b j=%b at %0d",
                  cyc, q[0].rej, q[0].j, q[0].at);
         void'(q.pop_front());
      end
   end

   task automatic expect_at(input bit rej, input bit j, input int at);
      q.push_back('{rej, j, at});
   endtask

   task automatic pulse(input int w);
      @(negedge clk);
      cif.coin_raw = 1'b1;
      repeat (w) @(negedge clk);
      cif.coin_raw = 1'b0;
   endtask

   task automatic coin(input int w, input bit rej, input bit j);
      pulse(w);
      expect_at(rej, j, cyc + 8);
      repeat (20) @(negedge clk);
   endtask

   // Drop hold so a buffered coin drains in the same cycle the
   // next coin classifies.
   task automatic collide(input int w, input bit rej, input bit j);
      cif.hold = 1'b1;
      pulse(20);
      repeat (20) @(negedge clk);
      pulse(w);
      expect_at(1'b0, 1'b1, cyc + 8);
      expect_at(rej, j, cyc + 9);
      repeat (7) @(negedge clk);
      cif.hold = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   initial begin
      rst          = 1'b1;
      cif.coin_raw = 1'b0;
      cif.hold     = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_i", int'(cif.i), 0);
      chk("rst_j", int'(cif.j), 0);
      chk("rst_reject", int'(cif.reject), 0);
      chk("rst_jam", int'(cif.jam), 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      coin(10, 1'b0, 1'b0);
      chk("jam_small", int'(cif.jam), 0);
      coin(20, 1'b0, 1'b1);
      coin(16, 1'b0, 1'b1);
      coin(15, 1'b0, 1'b0);
      coin(8, 1'b0, 1'b0);
      coin(31, 1'b0, 1'b1);
      coin(7, 1'b1, 1'b0);
      coin(5, 1'b1, 1'b0);

      pulse(2);
      repeat (20) @(negedge clk);

      // 3-cycle dropout is shorter than the debounce window
      @(negedge clk);
      cif.coin_raw = 1'b1;
      repeat (6) @(negedge clk);
      cif.coin_raw = 1'b0;
      repeat (3) @(negedge clk);
      cif.coin_raw = 1'b1;
      repeat (3) @(negedge clk);
      cif.coin_raw = 1'b0;
      expect_at(1'b0, 1'b0, cyc + 8);
      repeat (20) @(negedge clk);

      cif.hold = 1'b1;
      pulse(20);
      repeat (20) @(negedge clk);
      pulse(10);
      expect_at(1'b1, 1'b0, cyc + 8);
      repeat (20) @(negedge clk);
      expect_at(1'b0, 1'b1, cyc + 1);
      cif.hold = 1'b0;
      repeat (20) @(negedge clk);

      collide(5, 1'b1, 1'b0);
      collide(10, 1'b0, 1'b0);

      begin : jam_test
         int r;
         @(negedge clk);
         cif.coin_raw = 1'b1;
         r = cyc;
         repeat (37) @(negedge clk);
         chk("jam_before", int'(cif.jam), 0);
         @(negedge clk);
         chk("jam_rise", int'(cif.jam), 1);
         repeat (2) @(negedge clk);
         chk("jam_width", cyc - r, 40);
         cif.coin_raw = 1'b0;
         expect_at(1'b1, 1'b0, cyc + 8);
         repeat (6) @(negedge clk);
         chk("jam_hold", int'(cif.jam), 1);
         @(negedge clk);
         chk("jam_clear", int'(cif.jam), 0);
         repeat (20) @(negedge clk);
      end

      @(negedge clk);
      cif.coin_raw = 1'b1;
      repeat (38) @(negedge clk);
      chk("jam_pre_rst", int'(cif.jam), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_jam", int'(cif.jam), 0);
      chk("arst_i", int'(cif.i), 0);
      chk("arst_reject", int'(cif.reject), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      cif.coin_raw = 1'b0;
      repeat (30) @(negedge clk);
      coin(10, 1'b0, 1'b0);

      cif.hold = 1'b1;
      pulse(20);
      repeat (15) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      cif.hold = 1'b0;
      rst = 1'b0;
      repeat (20) @(negedge clk);
      coin(12, 1'b0, 1'b0);

      repeat (10) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/coin_detector.md
Name: coin_detector

Overview:
- Front-end stage directly upstream of the vending FSM; drives its `i`/`j` coin inputs.
- Synchronises and debounces the raw coin-chute sensor, measures pulse width, and classifies each coin as small (1 unit) or large (2 units).
- Emits one-cycle coin strobes. Holds one coin while the downstream FSM is busy dispensing (states s3/s4).
- Flags and returns invalid or overflow coins; flags a jammed sensor.

Parameters:
- DEB_CYC, 4: consecutive identical synchronised samples required before the filtered level changes.
- MIN_SMALL, 8: minimum filtered-high width, in cycles, for a small coin.
- MAX_SMALL, 15: maximum width for a small coin.
- MIN_LARGE, 16: minimum width for a large coin.
- MAX_LARGE, 31: maximum width for a large coin. Width MAX_LARGE+1 means jammed.
- CNT_W, 6: width-counter bits. Required: MIN_SMALL<=MAX_SMALL<MIN_LARGE<=MAX_LARGE<2^CNT_W-1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous reset, active-high.
- coin_raw, input, 1: raw chute sensor, asynchronous, high while a coin passes.
- hold, input, 1: downstream busy. While high, no coin strobe is emitted.
- i, output, 1: coin-valid strobe, one cycle.
- j, output, 1: coin-type bit, valid only with i. 1 = large, 0 = small.
- reject, output, 1: one-cycle strobe. Coin goes to return chute.
- jam, output, 1: level. Sensor high for longer than MAX_LARGE.

Behaviour:
Reset
- Reset is asynchronous and active-high: `rst` high immediately clears all state, independent of `clk`.
- All outputs reset to 0. Synchroniser, filtered level, debounce counter, width counter and buffer all cleared. FSM enters ARM.

Input conditioning
- Two-flop synchroniser on coin_raw.
- The filtered level changes only after the synchronised value differs from it for DEB_CYC consecutive cycles.
- Debounce counter clears on any agreeing sample.
- A clean raw pulse of width W gives a filtered pulse of width W. Pulses shorter than DEB_CYC are invisible.

FSM states
- ARM: wait for filtered=0, then go to IDLE. A coin partially through the chute at reset is ignored.
- IDLE: on filtered rising, width counter = 1, go to MEASURE.
- MEASURE, while filtered=1:
  - Counter increments and saturates at 2^CNT_W-1.
  - When counter reaches MAX_LARGE+1, jam rises and stays high until filtered falls.
- MEASURE, on filtered falling: go to CLASSIFY.
- CLASSIFY, one cycle, then IDLE:
  - Width in [MIN_SMALL,MAX_SMALL] gives a small coin.
  - Width in [MIN_LARGE,MAX_LARGE] gives a large coin.
  - Any other width gives a reject. Jam deasserts here.

Output stage (registered)
- Outputs asserted in the cycle after CLASSIFY.
- Total latency from the first clk edge that samples coin_raw low is DEB_CYC+4 cycles. Default: 8 cycles.
- Valid coin and hold=0 and buffer empty: i=1 for one cycle, j = type.
- Valid coin and hold=1: store in the 1-entry buffer (type bit plus full flag). No strobe.
- Buffer full and hold=0: emit the buffered coin (i=1, j=buffered type) and clear the buffer. This has priority over a new coin.
- New valid coin in the same cycle the buffer drains: the new coin goes into the buffer and is emitted next cycle if hold is still 0.
- Valid coin while buffer full and hold=1: reject=1, and the new coin is discarded.
- i and reject are never both high in the same cycle.
  - If a buffered coin drains while a new coin is rejected for width, reject is delayed one cycle.
- i is never high for two consecutive cycles from a single coin.
- Reset mid-MEASURE or with the buffer full: the coin is lost and no strobe is ever produced for it.

Test Plan:
- rst pulse, then coin_raw high 10 cycles clean -> one cycle i=1,j=0 exactly 8 cycles after raw falls; reject=0, jam=0.
- coin_raw high 20 cycles -> one cycle i=1,j=1. Then 16-cycle pulse -> i=1,j=1. 15-cycle pulse -> i=1,j=0.
- 5-cycle pulse -> reject=1 one cycle, i stays 0. 2-cycle glitch, and high-low-high chatter of 3-cycle segments inside a 12-cycle pulse -> glitch produces nothing; chattered pulse gives a single small coin.
- hold=1, 20-cycle pulse -> no strobe. Second 10-cycle pulse -> reject. Drop hold -> next cycle i=1,j=1, then buffer empty.
- coin_raw high 40 cycles -> jam rises on the 32nd filtered-high cycle and stays high until CLASSIFY; after raw falls, reject=1, jam=0.
- Assert rst asynchronously (between edges) mid-pulse -> all outputs 0 immediately. Release rst with raw still high -> no strobe for that coin; next clean 10-cycle pulse -> i=1,j=0.
